config_multiplier_serial: RTL

CONFIG_MULTIPLIER_SERIAL -- requirements
Module: config_multiplier_serial

---
 rtl/config_multiplier_serial.sv | 109 ++++++++++
 1 files changed

// File: rtl/config_multiplier_serial.sv
// rtl/config_multiplier_serial.sv - serial radix-4 multiplier, full width or two independent half-width lanes
module config_multiplier_serial #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic                 halvedPrecision,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int NUM_DIGITS = WIDTH / 2;
    localparam int CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW         = $clog2(2 * WIDTH);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] LANE_SPLIT = CW'(NUM_DIGITS / 2);

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("config_multiplier_serial: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mul_q;
    logic [WIDTH-1:0]     mcd_q;
    logic                 half_q;

    logic [1:0]           digit;
    logic [SW-1:0]        shamt;
    logic [2*WIDTH-1:0]   base;
    logic [2*WIDTH-1:0]   term;

    // Upper-lane digits sit WIDTH/2 bits higher in the accumulator so each
    // lane product lands in its own WIDTH-bit half with no cross-lane terms.
    always_comb begin
        digit = mul_q[{cnt, 1'b0} +: 2];
        shamt = SW'({cnt, 1'b0});
        base  = {{WIDTH{1'b0}}, mcd_q};
        if (half_q) begin
            if (cnt < LANE_SPLIT) begin
                base = {{(WIDTH + WIDTH/2){1'b0}}, mcd_q[WIDTH/2-1:0]};
            end else begin
                base  = {{(WIDTH + WIDTH/2){1'b0}}, mcd_q[WIDTH-1:WIDTH/2]};
                shamt = shamt + SW'(WIDTH / 2);
            end
        end
        term = (base * {{(2*WIDTH-2){1'b0}}, digit}) << shamt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mul_q  <= '0;
            mcd_q  <= '0;
            half_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mul_q  <= multiplier;
                        mcd_q  <= multiplicand;
                        half_q <= halvedPrecision;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc + term;
                    if (cnt == LAST_DIGIT) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);
    assign product   = out_valid ? acc : '0;

endmodule
